// File: rtl/vga_sync_decoder.sv
// Recovers h/v position, pixel coordinates and data-enable from sampled active-low HSYNC/VSYNC, with lock and fault tracking.
// Latency: HSYNC low sampled at edge N gives h_pos==0 at edge N+2; free-running, no backpressure.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 3200,
    parameter int H_SYNC      = 384,
    parameter int H_BACK      = 192,
    parameter int H_ACTIVE    = 2560,
    parameter int H_TOL       = 8,
    parameter int V_TOTAL     = 521,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 29,
    parameter int V_ACTIVE    = 480,
    parameter int PIX_LOG2    = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] h_pos,
    output logic [9:0]  v_line,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        de,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err,
    output logic [7:0]  err_count
);

    localparam logic [12:0] PERIOD_LO = 13'(H_TOTAL - H_TOL);
    localparam logic [12:0] PERIOD_HI = 13'(H_TOTAL + H_TOL);
    localparam logic [11:0] H_TIMEOUT = 12'(H_TOTAL + H_TOL - 1);
    localparam logic [11:0] H_DE0     = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_DE1     = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_DE0     = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_DE1     = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [10:0] V_LEN     = 11'(V_TOTAL);
    localparam int          GW        = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] good, good_nxt, good_inc;

    logic hs_s1, hs_s2, hs_hist;
    logic vs_s1, vs_s2, vs_hist;
    logic hfall, vfall;

    logic        v_pend;
    logic        h_seen;
    logic        f_seen;
    logic        to_fired;
    logic [12:0] period;
    logic        fs_now;
    logic        line_bad, frame_bad, timeout, bad;
    logic [11:0] h_off;

    // Synchronizers idle high so a reset never manufactures a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_s1   <= 1'b1;
            hs_s2   <= 1'b1;
            hs_hist <= 1'b1;
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_hist <= 1'b1;
        end else begin
            hs_s1   <= hsync_in;
            hs_s2   <= hs_s1;
            hs_hist <= hs_s2;
            vs_s1   <= vsync_in;
            vs_s2   <= vs_s1;
            vs_hist <= vs_s2;
        end
    end

    assign hfall = !hs_s2 && hs_hist;
    assign vfall = !vs_s2 && vs_hist;

    assign period    = {1'b0, h_pos} + 13'd1;
    assign fs_now    = hfall && (v_pend || vfall);
    assign line_bad  = hfall && h_seen && !to_fired &&
                       ((period < PERIOD_LO) || (period > PERIOD_HI));
    // A line that already timed out is reported once; its closing fall is not re-checked.
    assign timeout   = !hfall && h_seen && !to_fired && (h_pos == H_TIMEOUT);
    assign frame_bad = fs_now && f_seen && (({1'b0, v_line} + 11'd1) != V_LEN);
    assign bad       = line_bad || frame_bad || timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_pos       <= '0;
            v_line      <= '0;
            v_pend      <= 1'b0;
            h_seen      <= 1'b0;
            f_seen      <= 1'b0;
            to_fired    <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_start <= fs_now;
            sync_err    <= bad;

            if (hfall) begin
                h_pos  <= '0;
                h_seen <= 1'b1;
            end else if (h_pos != 12'hFFF) begin
                h_pos <= h_pos + 12'd1;
            end

            if (hfall) begin
                to_fired <= 1'b0;
            end else if (timeout) begin
                to_fired <= 1'b1;
            end

            if (fs_now) begin
                v_line <= '0;
                v_pend <= 1'b0;
                f_seen <= 1'b1;
            end else begin
                if (vfall) begin
                    v_pend <= 1'b1;
                end
                if (hfall && (v_line != 10'h3FF)) begin
                    v_line <= v_line + 10'd1;
                end
            end

            if (bad && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    assign good_inc = good + GW'(1);

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        case (state)
            SEARCH: begin
                if (!bad && fs_now) begin
                    state_nxt = MEASURE;
                    good_nxt  = '0;
                end
            end
            MEASURE: begin
                if (bad) begin
                    state_nxt = SEARCH;
                end else if (fs_now) begin
                    good_nxt = good_inc;
                    if (good_inc == GOOD_MAX) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (bad) begin
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);

    assign de = locked &&
                (h_pos >= H_DE0) && (h_pos < H_DE1) &&
                (v_line >= V_DE0) && (v_line < V_DE1);

    assign h_off = h_pos - H_DE0;
    assign pix_x = de ? 10'(h_off >> PIX_LOG2) : '0;
    assign pix_y = de ? 9'(v_line - V_DE0) : '0;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboarded bench for vga_sync_decoder using scaled-down timing (64 clk/line, 12 lines/frame).
module tb_vga_sync_decoder;

    localparam int HT = 64, HS = 8, HB = 4, HA = 48, HTOL = 2;
    localparam int VT = 12, VS = 2, VB = 2, VA = 6, PL = 2, LF = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] h_pos;
    logic [9:0]  v_line;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        de, locked, frame_start, sync_err;
    logic [7:0]  err_count;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOL(HTOL),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
        .PIX_LOG2(PL), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .h_pos(h_pos), .v_line(v_line), .pix_x(pix_x), .pix_y(pix_y),
        .de(de), .locked(locked), .frame_start(frame_start),
        .sync_err(sync_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit fs;
        bit err;
        bit lk;
        int ec;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Stimulus-side expectation state
    bit  m_hseen = 0, m_fseen = 0, m_vpend = 0, m_prev_to = 0, pend_coinc = 1;
    int  m_prev_period = HT, m_vline = 0, m_state = 0, m_good = 0, m_ec = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_event(input bit fs, input bit bad);
        ev_t e;
        if (bad) begin
            m_state = 0;
            if (m_ec < 255) m_ec++;
        end else if (fs) begin
            if (m_state == 0) begin
                m_state = 1;
                m_good  = 0;
            end else if (m_state == 1) begin
                m_good++;
                if (m_good == LF) m_state = 2;
            end
        end
        if (fs) m_fseen = 1;
        e.fs  = fs;
        e.err = bad;
        e.lk  = (m_state == 2);
        e.ec  = m_ec;
        exp_q.push_back(e);
    endtask

    // vmode: 0 none, 1 vsync falls mid-line, 2 vsync falls with this hsync, 3 vsync rises
    task automatic send_line(input int period, input int vmode);
        bit fs, bad;
        fs  = m_vpend || (vmode == 2);
        bad = 0;
        if (m_hseen && !m_prev_to && (m_prev_period < HT - HTOL)) bad = 1;
        if (fs && m_fseen && (m_vline + 1 != VT)) bad = 1;
        if (fs || bad) expect_event(fs, bad);
        m_vline = fs ? 0 : m_vline + 1;
        if (fs) m_vpend = 0;
        m_hseen   = 1;
        m_prev_to = (period > HT + HTOL);
        if (m_prev_to) expect_event(0, 1);
        m_prev_period = period;
        for (int c = 0; c < period; c++) begin
            @(posedge clk);
            #1;
            hsync_in = (c < HS) ? 1'b0 : 1'b1;
            if (vmode == 2 && c == 0)  vsync_in = 1'b0;
            if (vmode == 3 && c == 0)  vsync_in = 1'b1;
            if (vmode == 1 && c == 20) vsync_in = 1'b0;
        end
        if (vmode == 1) m_vpend = 1;
    endtask

    task automatic send_frame(input int nlines, input bit end_coinc,
                              input int bad_idx, input int bad_period);
        for (int l = 0; l < nlines; l++) begin
            int mode, per;
            mode = 0;
            if (l == 0 && pend_coinc)                  mode = 2;
            else if (l == 2)                           mode = 3;
            else if (l == nlines - 1 && !end_coinc)    mode = 1;
            per = (l == bad_idx) ? bad_period : HT;
            send_line(per, mode);
        end
        pend_coinc = end_coinc;
    endtask

    task automatic wait_hv(input string name, input int v, input int h, input int maxc);
        bit found;
        found = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (int'(v_line) == v && int'(h_pos) == h) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no v_line=%0d h_pos=%0d within %0d cycles", name, v, h, maxc);
        end
    endtask

    // Monitor: every frame_start / sync_err pulse consumes one expectation
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset && (frame_start || sync_err)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'({frame_start, sync_err}), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_frame_start", int'(frame_start), int'(e.fs));
                    chk("ev_sync_err",    int'(sync_err),    int'(e.err));
                    chk("ev_locked",      int'(locked),      int'(e.lk));
                    chk("ev_err_count",   int'(err_count),   e.ec);
                    if (e.fs) chk("ev_v_line_zero", int'(v_line), 0);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_h_pos"},       int'(h_pos), 0);
        chk({tag, "_v_line"},      int'(v_line), 0);
        chk({tag, "_pix_x"},       int'(pix_x), 0);
        chk({tag, "_pix_y"},       int'(pix_y), 0);
        chk({tag, "_de"},          int'(de), 0);
        chk({tag, "_locked"},      int'(locked), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_sync_err"},    int'(sync_err), 0);
        chk({tag, "_err_count"},   int'(err_count), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        repeat (10) @(posedge clk);

        // Nominal frames: lock on the third frame_start
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        chk("locked_after_2_frames", int'(locked), 0);
        send_frame(VT, 0, -1, 0);
        chk("locked_after_3_frames", int'(locked), 1);
        chk("err_count_nominal", int'(err_count), 0);

        // Active window: de spans h_pos 12..59, v_line 4..9
        fork
            send_frame(VT, 0, -1, 0);
            begin
                wait_hv("win_pre", 4, 11, 2000);
                chk("de_before_window", int'(de), 0);
                @(negedge clk);
                chk("de_first_pixel", int'(de), 1);
                chk("h_pos_first_pixel", int'(h_pos), 12);
                chk("pix_x_first", int'(pix_x), 0);
                chk("pix_y_first", int'(pix_y), 0);
                wait_hv("win_last", 4, 59, 200);
                chk("de_last_pixel", int'(de), 1);
                chk("pix_x_last", int'(pix_x), 11);
                @(negedge clk);
                chk("de_after_window", int'(de), 0);
                chk("pix_x_after_window", int'(pix_x), 0);
                wait_hv("win_bottom", 9, 30, 1000);
                chk("de_last_row", int'(de), 1);
                chk("pix_y_last_row", int'(pix_y), 5);
                chk("pix_x_mid", int'(pix_x), 4);
                wait_hv("win_below", 10, 30, 200);
                chk("de_below_window", int'(de), 0);
                chk("pix_y_below_window", int'(pix_y), 0);
            end
        join

        // One long line (68 > 66): drop lock, relock after two good frames
        send_frame(VT, 0, 5, HT + HTOL + 2);
        chk("locked_after_long_line", int'(locked), 0);
        chk("err_count_long_line", int'(err_count), 1);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        chk("relocked_after_long_line", int'(locked), 1);

        // One short line (58 < 62): caught at its closing hsync fall
        send_frame(VT, 0, 3, HT - HTOL - 4);
        chk("locked_after_short_line", int'(locked), 0);
        chk("err_count_short_line", int'(err_count), 2);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        chk("relocked_after_short_line", int'(locked), 1);

        // HSYNC held high for one line: single fault at h_pos 66, h_pos saturates
        fork
            send_frame(VT, 0, 5, 4200);
            begin
                wait_hv("hold_timeout", 5, HT + HTOL, 2000);
                chk("hold_sync_err", int'(sync_err), 1);
                chk("hold_locked", int'(locked), 0);
                wait_hv("hold_saturate", 5, 4095, 4500);
                chk("hold_h_pos_sat", int'(h_pos), 4095);
                @(negedge clk);
                chk("hold_h_pos_stays", int'(h_pos), 4095);
            end
        join
        chk("err_count_hold", int'(err_count), 3);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        chk("relocked_after_hold", int'(locked), 1);

        // 11-line frame, next frame starts with coincident vsync/hsync fall
        send_frame(VT - 1, 1, -1, 0);
        send_frame(VT, 0, -1, 0);
        chk("locked_after_short_frame", int'(locked), 0);
        chk("err_count_short_frame", int'(err_count), 4);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);

        // Reset mid-frame while locked
        send_frame(6, 1, -1, 0);
        chk("pre_reset_locked", int'(locked), 1);
        chk("pre_reset_v_line", int'(v_line), 5);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        m_hseen = 0; m_fseen = 0; m_vpend = 0; m_prev_to = 0;
        m_vline = 0; m_state = 0; m_good = 0; m_ec = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        send_frame(VT, 0, -1, 0);
        send_frame(VT, 0, -1, 0);
        chk("post_reset_not_locked", int'(locked), 0);
        send_frame(VT, 0, -1, 0);
        chk("post_reset_locked", int'(locked), 1);
        chk("post_reset_err_count", int'(err_count), 0);

        // Sync stops after the last line: one timeout
        expect_event(0, 1);
        repeat (100) @(negedge clk);
        chk("final_err_count", int'(err_count), 1);
        chk("final_locked", int'(locked), 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
